i2c_slave_sequencer: RTL and testbench

Top-level transaction sequencer for the I2C slave.
- Watches the SCL/SDA pairs (current and previous samples) in the FPGA_clk domain and detects START, STOP and SCL edges.
- Shifts in the 7-bit address plus the R/W bit, compares the address to SLAVE_ADDR, and ACKs matching writes.
- Hands a write transfer to the data_in_top_level datapath via enable/reset, then waits for its done.
- NACKs reads, NACKs address mismatches, and recovers from bus hangs with a watchdog.

---
 rtl/i2c_slave_pkg.sv | 17 +
 rtl/i2c_bus_cond_detect.sv | 22 ++
 rtl/i2c_slave_sequencer.sv | 139 +++++++++++++
 tb/tb_i2c_slave_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared I2C slave types: sequencer state encoding and bus field widths.
// Used by the sequencer, the data-in datapath and the future data-out block.
// Contents: seq_state_t, I2C_ADDR_W, I2C_BYTE_W.
package i2c_slave_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    WAIT_STOP
  } seq_state_t;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// I2C bus condition decode: START, STOP and SCL edges from current/previous samples.
// Latency: purely combinational, no backpressure.
// Ports: SCL, SCL_prev, SDA, SDA_prev in; start, stop, scl_rise, scl_fall out.
module i2c_bus_cond_detect (
  input  logic SCL,
  input  logic SCL_prev,
  input  logic SDA,
  input  logic SDA_prev,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall
);

  assign scl_rise = SCL & ~SCL_prev;
  assign scl_fall = ~SCL & SCL_prev;
  // SDA may only change with SCL low, so an SDA edge while SCL stays high
  // is a bus condition; the two SDA directions cannot coincide.
  assign start    = SCL & SCL_prev & SDA_prev & ~SDA;
  assign stop     = SCL & SCL_prev & ~SDA_prev & SDA;

endmodule

// File: rtl/i2c_slave_sequencer.sv
// I2C slave transaction sequencer: address decode/ACK, datapath handoff, hang watchdog.
// Latency: every output is registered, 1 FPGA_clk after the sampled bus condition.
// Backpressure: none; DATA waits on data_done. Ports: FPGA_clk, rst, SCL/SDA (+_prev),
//   data_done in; data_enable, data_rst, SDA_down, addr_match, busy, timeout out.
module i2c_slave_sequencer
  import i2c_slave_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR     = 7'h42,
  parameter int                    NUM_BYTES      = 6,
  parameter int                    TIMEOUT_CYCLES = 2_000_000
) (
  input  logic FPGA_clk,
  input  logic rst,
  input  logic SCL,
  input  logic SCL_prev,
  input  logic SDA,
  input  logic SDA_prev,
  input  logic data_done,
  output logic data_enable,
  output logic data_rst,
  output logic SDA_down,
  output logic addr_match,
  output logic busy,
  output logic timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // The byte count belongs to the datapath; reject a meaningless value early.
  if (NUM_BYTES < 1) begin : g_num_bytes_invalid
    $error("i2c_slave_sequencer: NUM_BYTES must be at least 1");
  end

  seq_state_t            state, state_nxt;
  logic                  start, stop, scl_rise, scl_fall;
  logic [I2C_BYTE_W-1:0] shift_reg;
  logic [2:0]            bit_cnt;
  logic                  addr_done;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_expired;
  logic                  data_rst_nxt, addr_match_nxt, timeout_nxt;

  i2c_bus_cond_detect u_cond (
    .SCL      (SCL),
    .SCL_prev (SCL_prev),
    .SDA      (SDA),
    .SDA_prev (SDA_prev),
    .start    (start),
    .stop     (stop),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  // An SCL edge in the same cycle clears the count, so it also vetoes expiry.
  assign wd_expired = (state != IDLE) && !scl_rise && !scl_fall &&
                      (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt      = state;
    data_rst_nxt   = 1'b0;
    addr_match_nxt = 1'b0;
    timeout_nxt    = 1'b0;
    if (start) begin
      state_nxt    = ADDR;
      data_rst_nxt = 1'b1;
    end else if (stop) begin
      state_nxt = IDLE;
    end else if (wd_expired) begin
      state_nxt   = IDLE;
      timeout_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        ADDR: begin
          // Decide on the falling edge after bit 8 so SDA_down is driven
          // while SCL is low, ahead of the ACK clock.
          if (scl_fall && addr_done) begin
            if ((shift_reg[I2C_BYTE_W-1:1] == SLAVE_ADDR) && !shift_reg[0]) begin
              state_nxt      = ADDR_ACK;
              addr_match_nxt = 1'b1;
            end else begin
              state_nxt = WAIT_STOP;
            end
          end
        end
        ADDR_ACK:  if (scl_fall) state_nxt = DATA;
        DATA:      if (data_done) state_nxt = WAIT_STOP;
        WAIT_STOP: state_nxt = WAIT_STOP;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // State register; the level outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge FPGA_clk) begin
    if (rst) begin
      state       <= IDLE;
      data_enable <= 1'b0;
      data_rst    <= 1'b0;
      SDA_down    <= 1'b0;
      addr_match  <= 1'b0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      data_enable <= (state_nxt == DATA);
      SDA_down    <= (state_nxt == ADDR_ACK);
      busy        <= (state_nxt != IDLE);
      data_rst    <= data_rst_nxt;
      addr_match  <= addr_match_nxt;
      timeout     <= timeout_nxt;
    end
  end

  // Address shifter: MSB first on SCL rise; a (repeated) START restarts it.
  always_ff @(posedge FPGA_clk) begin
    if (rst || start) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      addr_done <= 1'b0;
    end else if ((state == ADDR) && scl_rise) begin
      shift_reg <= {shift_reg[I2C_BYTE_W-2:0], SDA};
      bit_cnt   <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) addr_done <= 1'b1;
    end
  end

  // Bus-hang watchdog. It restarts at its expiry point even if a START/STOP
  // wins that cycle, so it never needs to saturate.
  always_ff @(posedge FPGA_clk) begin
    if (rst || (state == IDLE) || scl_rise || scl_fall || wd_expired) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_i2c_slave_sequencer.sv
// Randomized bench for i2c_slave_sequencer: a bus-level master drives START,
// address/data bytes, data_done, STOP, repeated START and hangs; expectations
// come from transaction-level rules (ACK iff addr==0x42 and write).
module tb_i2c_slave_sequencer;

  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1, scl_prev = 1'b1, sda = 1'b1, sda_prev = 1'b1;
  logic data_done = 1'b0;
  logic data_enable, data_rst, sda_down, addr_match, busy, timeout;

  int total = 0, bad = 0;
  int cyc = 0, n_rst = 0, n_match = 0, n_to = 0;
  int last_edge = 0, h = 2, tx_r0 = 0;
  bit exp_busy = 1'b0;
  int exp_starts = 0, exp_acks = 0, exp_tos = 0;

  i2c_slave_sequencer #(
    .SLAVE_ADDR     (7'h42),
    .NUM_BYTES      (6),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .FPGA_clk    (clk),
    .rst         (rst),
    .SCL         (scl),
    .SCL_prev    (scl_prev),
    .SDA         (sda),
    .SDA_prev    (sda_prev),
    .data_done   (data_done),
    .data_enable (data_enable),
    .data_rst    (data_rst),
    .SDA_down    (sda_down),
    .addr_match  (addr_match),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled shortly after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (data_rst)   n_rst   = n_rst + 1;
    if (addr_match) n_match = n_match + 1;
    if (timeout)    n_to    = n_to + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ack(input logic [7:0] b);
    return (b[7:1] == 7'h42) && (b[0] == 1'b0);
  endfunction

  // One FPGA_clk of bus: the line is the wired-AND of master and slave.
  task automatic step(input logic s_cl, input logic s_da, input logic dd);
    @(negedge clk);
    if (s_cl !== scl) last_edge = cyc + 1;
    scl_prev  = scl;
    sda_prev  = sda;
    scl       = s_cl;
    sda       = s_da & ~sda_down;
    data_done = dd;
  endtask

  task automatic drive(input logic s_cl, input logic s_da, input int n);
    for (int i = 0; i < n; i++) step(s_cl, s_da, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb);
    for (int i = 7; i >= 8 - nb; i--) begin
      drive(1'b0, b[i], h);
      drive(1'b1, b[i], h);
    end
  endtask

  task automatic do_start(input logic dd);
    if (!(scl && sda)) begin
      drive(1'b0, 1'b1, h);
      drive(1'b1, 1'b1, h);
    end
    step(1'b1, 1'b0, dd);
    if (!exp_busy) last_edge = cyc + 1;
    step(1'b1, 1'b0, 1'b0);
    chk("start_data_rst", data_rst, 1);
    chk("start_data_en", data_enable, 0);
    chk("start_sda_down", sda_down, 0);
    chk("start_busy", busy, 1);
    drive(1'b1, 1'b0, h - 2);
    exp_busy = 1'b1;
    exp_starts++;
  endtask

  task automatic send_addr(input logic [7:0] b);
    int m0;
    bit ack;
    ack = addr_ack(b);
    m0  = n_match;
    send_bits(b, 8);
    drive(1'b0, 1'b1, h);
    chk("ack_low_sda_down", sda_down, ack);
    drive(1'b1, 1'b1, h);
    chk("ack_high_sda_down", sda_down, ack);
    chk("ack_line", sda, !ack);
    drive(1'b0, 1'b1, h);
    chk("post_ack_en", data_enable, ack);
    chk("post_ack_sda_down", sda_down, 0);
    chk("addr_match_cnt", n_match - m0, ack);
    chk("post_ack_busy", busy, 1);
    if (ack) exp_acks++;
  endtask

  task automatic send_data(input logic [7:0] b, input bit en);
    send_bits(b, 8);
    drive(1'b0, 1'b1, h);
    drive(1'b1, 1'b1, h);
    drive(1'b0, 1'b1, h);
    chk("data_byte_en", data_enable, en);
    chk("data_byte_sda_down", sda_down, 0);
  endtask

  task automatic end_stop();
    drive(1'b0, 1'b0, h);
    drive(1'b1, 1'b0, h);
    drive(1'b1, 1'b1, h);
    chk("stop_busy", busy, 0);
    chk("stop_en", data_enable, 0);
    chk("stop_sda_down", sda_down, 0);
    chk("stop_no_data_rst", n_rst - tx_r0, 0);
    exp_busy = 1'b0;
    drive(1'b1, 1'b1, h);
  endtask

  task automatic hang();
    int t0, at;
    bit seen;
    t0 = last_edge;
    at = 0;
    seen = 1'b0;
    for (int i = 0; i < 3 * TO && !seen; i++) begin
      step(scl, sda, 1'b0);
      if (timeout) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    chk("timeout_seen", seen, 1);
    chk("timeout_cycle", at - t0, TO);
    chk("timeout_busy", busy, 0);
    chk("timeout_en", data_enable, 0);
    chk("timeout_sda_down", sda_down, 0);
    exp_busy = 1'b0;
    exp_tos++;
  endtask

  initial begin
    logic [7:0] b;
    bit ack;
    int r;

    repeat (3) @(negedge clk);
    chk("rst_data_en", data_enable, 0);
    chk("rst_data_rst", data_rst, 0);
    chk("rst_sda_down", sda_down, 0);
    chk("rst_addr_match", addr_match, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 4);

    for (int t = 0; t < 40; t++) begin
      h = $urandom_range(2, 4);
      do_start($urandom_range(0, 3) == 0);
      tx_r0 = n_rst;
      if ($urandom_range(0, 7) == 0) begin
        hang();
      end else begin
        if ($urandom_range(0, 5) == 0) begin
          send_bits(8'($urandom), $urandom_range(1, 7));
          do_start(1'b0);
          tx_r0 = n_rst;
        end
        r = $urandom_range(0, 4);
        b = (r < 2) ? 8'h84 : (r == 2) ? 8'h85 : (r == 3) ? 8'h86 : 8'($urandom);
        ack = addr_ack(b);
        send_addr(b);
        for (int k = $urandom_range(0, 6); k > 0; k--) send_data(8'($urandom), ack);
        if ($urandom_range(0, 1) == 1) begin
          step(1'b0, 1'b1, 1'b1);
          step(1'b0, 1'b1, 1'b0);
          chk("done_en", data_enable, 0);
          chk("done_busy", busy, 1);
          drive(1'b0, 1'b1, h);
        end
        r = $urandom_range(0, 3);
        if (r < 2) end_stop();
        else if (r == 3) hang();
        // r == 2: next iteration issues a repeated START
      end
    end

    // Directed: hang right after START, data_done colliding with START, reset in DATA.
    h = 2;
    do_start(1'b0);
    hang();
    do_start(1'b0);
    send_addr(8'h84);
    do_start(1'b1);
    send_addr(8'h84);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_data_en_data", data_enable, 0);
    chk("rst_sda_down_data", sda_down, 0);
    chk("rst_busy_data", busy, 0);
    chk("rst_data_rst_data", data_rst, 0);
    rst = 1'b0;
    exp_busy = 1'b0;
    drive(1'b0, 1'b1, 4);

    chk("total_data_rst", n_rst, exp_starts);
    chk("total_addr_match", n_match, exp_acks);
    chk("total_timeout", n_to, exp_tos);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
